// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_bank_arbiter_pkg : shared encodings and sizes for the bank    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package reg_bank_arbiter_pkg;

  localparam int NREQ_DEF = 3;
  localparam int NREG_DEF = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 32;
  localparam int PTR_W    = 2;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_e;

endpackage : reg_bank_arbiter_pkg
`default_nettype wire

// File: rtl/en_reg32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | en_reg32 : 32-bit register with load enable, sync active-low rst  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module en_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : en_reg32
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : round-robin pick, search starts at ptr_i             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_o,
  output logic             valid_o
);

  int idx;

  always_comb begin
    win_o = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_i) + i) % NREQ;
      if (win_o == '0 && req_i[idx]) begin
        win_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_bank_arbiter : round-robin access from 3 requesters to a bank |
// | of 32-bit registers (address 0 hardwired to zero)                 |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [ADDR_W*NREQ-1:0]   addr,
  input  logic [DATA_W*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy
);

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [NREQ-1:0]     gnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NREQ-1:0]     win;
  logic                win_valid;
  logic [PTR_W-1:0]    win_idx;
  logic [DATA_W-1:0]   bank_q [NREG];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  assign ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

  // Winner's request fields are captured on entry to XFER so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (win_valid) begin
            state_q <= ST_XFER;
            gnt_q   <= win;
            ptr_q   <= ptr_d;
            wr_q    <= wr[win_idx];
            addr_q  <= addr[ADDR_W*int'(win_idx) +: ADDR_W];
            wdata_q <= wdata[DATA_W*int'(win_idx) +: DATA_W];
          end
        end
        ST_XFER: begin
          state_q <= ST_ARB;
          gnt_q   <= '0;
        end
        default: begin
          state_q <= ST_ARB;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bank_q[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_bank
    logic en;
    assign en = (state_q == ST_XFER) && wr_q && (addr_q == ADDR_W'(i));
    en_reg32 u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .d_i  (wdata_q),
      .q_o  (bank_q[i])
    );
  end

  assign gnt   = gnt_q;
  assign busy  = (state_q == ST_XFER);
  assign rdata = (rst && state_q == ST_XFER && !wr_q) ? bank_q[addr_q] : '0;

endmodule : reg_bank_arbiter
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_bank_arbiter : directed self-checking bench                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [8:0]  addr;
  logic [95:0] wdata;
  logic [2:0]  gnt;
  logic [31:0] rdata;
  logic        busy;

  int n_checks;
  int n_errors;

  reg_bank_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .rdata (rdata),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic w, input logic [2:0] a, input logic [31:0] d);
    req[k]            = 1'b1;
    wr[k]             = w;
    addr[3*k +: 3]    = a;
    wdata[32*k +: 32] = d;
  endtask

  task automatic clr_req();
    req = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b0;
    req   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // Requester 1 writes DEADBEEF to addr 5, requester 0 reads it back
    set_req(1, 1'b1, 3'd5, 32'hDEADBEEF);
    step();
    chk("wr1_gnt", 32'(gnt), 32'h2);
    chk("wr1_busy", 32'(busy), 32'h1);
    chk("wr1_rdata", rdata, 32'h0);
    clr_req();
    step();
    chk("wr1_arb_gnt", 32'(gnt), 32'h0);
    chk("wr1_arb_busy", 32'(busy), 32'h0);
    set_req(0, 1'b0, 3'd5, 32'h0);
    step();
    chk("rd0_gnt", 32'(gnt), 32'h1);
    chk("rd0_rdata", rdata, 32'hDEADBEEF);
    clr_req();
    step();
    chk("rd0_after_rdata", rdata, 32'h0);

    // ptr is 1: grant requester 1 (read) to move ptr to 2
    set_req(1, 1'b0, 3'd5, 32'h0);
    step();
    chk("rd1_gnt", 32'(gnt), 32'h2);
    chk("rd1_rdata", rdata, 32'hDEADBEEF);
    clr_req();
    step();
    // ptr = 2 with req = 011 -> requester 0 wins, ptr becomes 1
    set_req(0, 1'b0, 3'd0, 32'h0);
    set_req(1, 1'b0, 3'd0, 32'h0);
    step();
    chk("ptr2_gnt", 32'(gnt), 32'h1);
    step();
    chk("ptr2_idle", 32'(gnt), 32'h0);
    step();
    chk("ptr1_gnt", 32'(gnt), 32'h2);
    clr_req();
    step();

    // ptr = 2: write to addr 0 is discarded
    set_req(2, 1'b1, 3'd0, 32'h12345678);
    step();
    chk("wr0addr_gnt", 32'(gnt), 32'h4);
    clr_req();
    step();
    set_req(0, 1'b0, 3'd0, 32'h0);
    step();
    chk("rdaddr0_gnt", 32'(gnt), 32'h1);
    chk("rdaddr0_rdata", rdata, 32'h0);
    clr_req();
    step();

    // Inputs changed during XFER must not disturb the latched transfer
    set_req(0, 1'b1, 3'd6, 32'hAAAA5555);
    step();
    chk("latch_gnt", 32'(gnt), 32'h1);
    addr[2:0]   = 3'd7;
    wdata[31:0] = 32'h11111111;
    clr_req();
    step();
    set_req(0, 1'b0, 3'd6, 32'h0);
    step();
    chk("latch_rd6", rdata, 32'hAAAA5555);
    clr_req();
    step();
    set_req(0, 1'b0, 3'd7, 32'h0);
    step();
    chk("latch_rd7", rdata, 32'h0);
    clr_req();
    step();

    // Reset during XFER aborts the write
    set_req(2, 1'b1, 3'd3, 32'hCAFEF00D);
    step();
    chk("abort_gnt", 32'(gnt), 32'h4);
    rst = 1'b0;
    clr_req();
    #1;
    chk("abort_rdata_rst", rdata, 32'h0);
    step();
    chk("abort_gnt_after", 32'(gnt), 32'h0);
    chk("abort_busy_after", 32'(busy), 32'h0);

    // All three requesting from reset: 001, idle, 010, idle, 100, idle, 001
    req  = 3'b111;
    wr   = 3'b000;
    addr = '0;
    rst  = 1'b1;
    step();
    chk("rr_g0", 32'(gnt), 32'h1);
    step();
    chk("rr_i0", 32'(gnt), 32'h0);
    step();
    chk("rr_g1", 32'(gnt), 32'h2);
    step();
    chk("rr_i1", 32'(gnt), 32'h0);
    step();
    chk("rr_g2", 32'(gnt), 32'h4);
    step();
    chk("rr_i2", 32'(gnt), 32'h0);
    step();
    chk("rr_g3", 32'(gnt), 32'h1);
    clr_req();
    step();

    // Bank contents were cleared by the reset
    set_req(0, 1'b0, 3'd3, 32'h0);
    step();
    chk("post_rst_rd3", rdata, 32'h0);
    clr_req();
    step();
    set_req(0, 1'b0, 3'd5, 32'h0);
    step();
    chk("post_rst_rd5_gnt", 32'(gnt), 32'h1);
    chk("post_rst_rd5", rdata, 32'h0);
    clr_req();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_bank_arbiter
`default_nettype wire

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, the number of requesters (fixed at 3 for this release).
REQ-002 The block SHALL have parameter NREG, default 8, the number of 32-bit bank registers; addresses are 3 bits wide.
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port req  input  3  per-requester access request, held high until granted.
REQ-006 Port wr  input  3  per-requester direction: 1 = write, 0 = read.
REQ-007 Port addr  input  9  per-requester 3-bit register address, requester k at bits [3k+2:3k].
REQ-008 Port wdata  input  96  per-requester 32-bit write data, requester k at bits [32k+31:32k].
REQ-009 Port gnt  output  3  one-hot grant, high for exactly one cycle per transfer.
REQ-010 Port rdata  output  32  read data, valid only while gnt is nonzero and the granted access is a read.
REQ-011 Port busy  output  1  high while in XFER state.

Function
REQ-012 The block SHALL use a two-state FSM: ARB and XFER.
REQ-013 In ARB with any req bit high, the block SHALL choose a winner round-robin starting at pointer ptr, latch its wr/addr/wdata, and go to XFER next cycle.
REQ-014 In ARB with req == 0, the block SHALL remain in ARB with gnt == 0.
REQ-015 In XFER, gnt SHALL be the one-hot code of the latched winner and the FSM SHALL return to ARB unconditionally.
REQ-016 A granted write SHALL update bank[addr] at the rising edge ending XFER; a read SHALL drive rdata = bank[addr] combinationally during XFER.
REQ-017 Address 0 SHALL read as 32'h0 and writes to it SHALL be discarded.
REQ-018 After each grant to requester k, ptr SHALL become (k+1) mod 3.
REQ-019 Latency: request sampled in cycle N produces gnt in cycle N+1 and write-visible data from cycle N+2; peak throughput is one transfer per 2 cycles.
REQ-020 A requester holding req high in the cycle after its gnt SHALL be treated as a new request.
REQ-021 Changes to req/wr/addr/wdata during XFER SHALL NOT affect the in-flight transfer.
REQ-022 A read of register r in the XFER cycle that follows a write to r SHALL return the new value.
REQ-023 rdata SHALL be 32'h0 whenever gnt == 0 or the granted access is a write.

Reset
REQ-024 With rst low at a rising edge, state SHALL become ARB, ptr 0, all bank registers 32'h0, gnt 0, busy 0.
REQ-025 Reset asserted during XFER SHALL abort the transfer: no bank write, gnt 0 from the next cycle.
REQ-026 rdata SHALL be 32'h0 while in reset.

Structure
REQ-027 State encodings (ARB, XFER), NREQ, NREG and address width SHALL live in a shared package.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter, taking req[2:0] and ptr[1:0] and returning a one-hot winner and a valid flag.
REQ-029 Bank storage SHALL be built from the codebase's existing 32-bit enabled register primitive, one instance per address 1..7.

Verification
REQ-030 Reset, then requester 1 writes 32'hDEADBEEF to addr 5 -> gnt = 3'b010 one cycle later; requester 0 reads addr 5 -> rdata = 32'hDEADBEEF.
REQ-031 All three requesters hold req continuously from reset -> gnt sequence 001, 010, 100, 001 with one idle ARB cycle between grants.
REQ-032 Write 32'h12345678 to addr 0, then read addr 0 -> rdata = 32'h0.
REQ-033 Requester 2 write to addr 3 is granted; rst driven low during its XFER -> addr 3 reads 32'h0 after reset, gnt 0 the cycle after reset.
REQ-034 Requester 0 changes addr and wdata during XFER -> the originally latched addr and wdata are written.
REQ-035 ptr = 2 with req = 3'b011 -> gnt = 3'b001, then ptr = 1.
